// File: rtl/updi_target_responder.sv
// updi_target_responder
//   Device end of a UPDI link. Parses SYNC / opcode / address / data / key
//   fields arriving from a UART RX FIFO, services LDS, STS, LDCS, STCS and
//   KEY against an internal CS register file and a small byte memory, and
//   pushes read data and ACKs into a UART TX FIFO.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rx_data          RX FIFO head, valid the cycle after rx_rd_en
//   rx_rd_en         pop RX FIFO (never on consecutive cycles)
//   rx_empty         RX FIFO empty
//   tx_data          byte pushed into TX FIFO
//   tx_wr_en         push TX FIFO (only when !tx_full)
//   tx_full          TX FIFO full; pending byte is held
//   break_detect     one-cycle BREAK pulse, returns parser to WAIT_SYNC
//   locked           ASI_SYS_STATUS.LOCKSTATUS
//   erase_active     high while the memory erase sweep runs
//   protocol_error   one-cycle pulse on bad SYNC or unsupported opcode
module updi_target_responder #(
  parameter int          MEM_SIZE      = 256,
  parameter int          MEM_ADDR_BITS = $clog2(MEM_SIZE),
  parameter logic [15:0] MEM_BASE      = 16'h8000,
  parameter logic [7:0]  STATUSA_RESET = 8'h30,
  parameter logic [63:0] KEY_CHIPERASE = 64'h4E564D4572617365
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  output logic       rx_rd_en,
  input  logic       rx_empty,
  output logic [7:0] tx_data,
  output logic       tx_wr_en,
  input  logic       tx_full,
  input  logic       break_detect,
  output logic       locked,
  output logic       erase_active,
  output logic       protocol_error
);

  typedef enum logic [3:0] {
    S_WAIT_SYNC,
    S_OPCODE,
    S_ADDR,
    S_ACK_ADDR,
    S_DATA_RX,
    S_ACK_DATA,
    S_DATA_TX,
    S_KEY_RX,
    S_KEY_TX,
    S_ERASE
  } state_t;

  typedef enum logic [2:0] {
    OP_LDS,
    OP_STS,
    OP_LDCS,
    OP_STCS,
    OP_KEY
  } op_t;

  localparam logic [7:0]  UPDI_ACK  = 8'h40;
  localparam logic [7:0]  UPDI_SYNC = 8'h55;
  // "UPDIFPGA", first character in the top byte
  localparam logic [63:0] DEVICE_ID = 64'h5550444946504741;

  state_t                   state, state_n;
  op_t                      op, op_n;
  logic                     size_a, size_a_n;
  logic                     size_b, size_b_n;
  logic                     size_c, size_c_n;
  logic [3:0]               cs_addr, cs_addr_n;
  logic [15:0]              addr, addr_n;
  logic [3:0]               idx, idx_n;
  logic [63:0]              key_sr, key_sr_n;
  logic [MEM_ADDR_BITS-1:0] erase_cnt, erase_cnt_n;
  logic                     locked_n;
  logic                     key_ok, key_ok_n;
  logic                     rx_pending, rx_pending_n;
  logic [7:0]               cs_file [16];

  logic [7:0]               mem [MEM_SIZE];

  logic                     mem_we;
  logic [MEM_ADDR_BITS-1:0] mem_wa;
  logic [7:0]               mem_wd;
  logic                     cs_we;
  logic [7:0]               cs_wd;

  logic [15:0]              cur_addr;
  logic [16:0]              mem_off;
  logic                     in_range;
  logic                     mem_ok;
  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic [7:0]               mem_rd;
  logic [7:0]               cs_rd;
  logic                     cs_writable;
  logic [63:0]              key_next;
  logic [63:0]              id_shift;
  logic                     need_byte;

  // Byte address for the current data byte; wraps at 16 bits.
  assign cur_addr = addr + {12'b0, idx};
  assign mem_off  = {1'b0, cur_addr} - {1'b0, MEM_BASE};
  assign in_range = !mem_off[16] && (mem_off < 17'(MEM_SIZE));
  assign mem_idx  = mem_off[MEM_ADDR_BITS-1:0];
  assign mem_ok   = in_range && !locked;
  assign mem_rd   = mem_ok ? mem[mem_idx] : 8'h00;

  assign key_next = {rx_data, key_sr[63:8]};
  assign id_shift = DEVICE_ID << {idx[2:0], 3'b000};

  assign cs_writable = !(cs_addr == 4'h0 || cs_addr == 4'h7 || cs_addr == 4'hB);

  // CS 0x7 bit3 is the chip-erase key flag; CS 0xB mirrors lock state and
  // the armed erase request.
  always_comb begin
    case (cs_addr)
      4'h0:    cs_rd = STATUSA_RESET;
      4'h7:    cs_rd = {4'b0, key_ok, 3'b0};
      4'hB:    cs_rd = {2'b0, (cs_file[8] == 8'h59), 4'b0, locked};
      default: cs_rd = cs_file[cs_addr];
    endcase
  end

  assign need_byte = (state == S_WAIT_SYNC) || (state == S_OPCODE) ||
                     (state == S_ADDR) || (state == S_DATA_RX) ||
                     (state == S_KEY_RX);

  always_comb begin
    state_n        = state;
    op_n           = op;
    size_a_n       = size_a;
    size_b_n       = size_b;
    size_c_n       = size_c;
    cs_addr_n      = cs_addr;
    addr_n         = addr;
    idx_n          = idx;
    key_sr_n       = key_sr;
    erase_cnt_n    = erase_cnt;
    locked_n       = locked;
    key_ok_n       = key_ok;
    rx_rd_en       = 1'b0;
    tx_wr_en       = 1'b0;
    tx_data        = '0;
    protocol_error = 1'b0;
    mem_we         = 1'b0;
    mem_wa         = mem_idx;
    mem_wd         = rx_data;
    cs_we          = 1'b0;
    cs_wd          = rx_data;

    if (rst) begin
      state_n = S_WAIT_SYNC;
    end else if (break_detect) begin
      state_n = S_WAIT_SYNC;
      idx_n   = '0;
    end else begin
      // A pop is issued only while no byte is in flight, so pops are at
      // least two cycles apart.
      rx_rd_en = need_byte && !rx_empty && !rx_pending;

      case (state)
        S_WAIT_SYNC: begin
          if (rx_pending) begin
            if (rx_data == UPDI_SYNC) begin
              state_n = S_OPCODE;
            end else begin
              protocol_error = 1'b1;
            end
          end
        end

        S_OPCODE: begin
          if (rx_pending) begin
            idx_n   = '0;
            state_n = S_WAIT_SYNC;
            case (rx_data[7:5])
              3'b000, 3'b010: begin
                if (rx_data[3] || rx_data[1]) begin
                  protocol_error = 1'b1;
                end else begin
                  op_n     = (rx_data[6]) ? OP_STS : OP_LDS;
                  size_a_n = rx_data[2];
                  size_b_n = rx_data[0];
                  state_n  = S_ADDR;
                end
              end
              3'b100: begin
                op_n      = OP_LDCS;
                cs_addr_n = rx_data[3:0];
                state_n   = S_DATA_TX;
              end
              3'b110: begin
                op_n      = OP_STCS;
                cs_addr_n = rx_data[3:0];
                state_n   = S_DATA_RX;
              end
              3'b111: begin
                if (rx_data[1]) begin
                  protocol_error = 1'b1;
                end else begin
                  op_n     = OP_KEY;
                  size_c_n = rx_data[0];
                  state_n  = rx_data[2] ? S_KEY_TX : S_KEY_RX;
                end
              end
              default: protocol_error = 1'b1;
            endcase
          end
        end

        S_ADDR: begin
          if (rx_pending) begin
            if (idx == 4'd0) begin
              addr_n = {8'h00, rx_data};
            end else begin
              addr_n = {rx_data, addr[7:0]};
            end
            if (idx == 4'd0 && size_a) begin
              idx_n = 4'd1;
            end else begin
              idx_n   = '0;
              state_n = (op == OP_STS) ? S_ACK_ADDR : S_DATA_TX;
            end
          end
        end

        S_ACK_ADDR: begin
          tx_data = UPDI_ACK;
          if (!tx_full) begin
            tx_wr_en = 1'b1;
            state_n  = S_DATA_RX;
          end
        end

        S_DATA_RX: begin
          if (rx_pending) begin
            if (op == OP_STCS) begin
              cs_we   = cs_writable;
              state_n = S_WAIT_SYNC;
              // Second half of the erase handshake: 0x59 then 0x00 to CS 0x8
              // with the key accepted.
              if (cs_addr == 4'h8 && rx_data == 8'h00 &&
                  cs_file[8] == 8'h59 && key_ok) begin
                erase_cnt_n = '0;
                state_n     = S_ERASE;
              end
            end else begin
              mem_we = mem_ok;
              if (idx == {3'b0, size_b}) begin
                idx_n   = '0;
                state_n = S_ACK_DATA;
              end else begin
                idx_n = idx + 4'd1;
              end
            end
          end
        end

        S_ACK_DATA: begin
          tx_data = UPDI_ACK;
          if (!tx_full) begin
            tx_wr_en = 1'b1;
            state_n  = S_WAIT_SYNC;
          end
        end

        S_DATA_TX: begin
          tx_data = (op == OP_LDCS) ? cs_rd : mem_rd;
          if (!tx_full) begin
            tx_wr_en = 1'b1;
            if (op == OP_LDCS || idx == {3'b0, size_b}) begin
              idx_n   = '0;
              state_n = S_WAIT_SYNC;
            end else begin
              idx_n = idx + 4'd1;
            end
          end
        end

        S_KEY_RX: begin
          if (rx_pending) begin
            key_sr_n = key_next;
            if (idx == (size_c ? 4'd15 : 4'd7)) begin
              idx_n   = '0;
              state_n = S_WAIT_SYNC;
              if (!size_c && key_next == KEY_CHIPERASE) begin
                key_ok_n = 1'b1;
              end
            end else begin
              idx_n = idx + 4'd1;
            end
          end
        end

        S_KEY_TX: begin
          tx_data = id_shift[63:56];
          if (!tx_full) begin
            tx_wr_en = 1'b1;
            if (idx == 4'd7) begin
              idx_n   = '0;
              state_n = S_WAIT_SYNC;
            end else begin
              idx_n = idx + 4'd1;
            end
          end
        end

        S_ERASE: begin
          mem_we = 1'b1;
          mem_wa = erase_cnt;
          mem_wd = 8'hFF;
          if (erase_cnt == MEM_ADDR_BITS'(MEM_SIZE - 1)) begin
            locked_n = 1'b0;
            key_ok_n = 1'b0;
            state_n  = S_WAIT_SYNC;
          end else begin
            erase_cnt_n = erase_cnt + 1'b1;
          end
        end

        default: state_n = S_WAIT_SYNC;
      endcase
    end

    rx_pending_n = rx_rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT_SYNC;
      op         <= OP_LDS;
      size_a     <= 1'b0;
      size_b     <= 1'b0;
      size_c     <= 1'b0;
      cs_addr    <= '0;
      addr       <= '0;
      idx        <= '0;
      key_sr     <= '0;
      erase_cnt  <= '0;
      locked     <= 1'b1;
      key_ok     <= 1'b0;
      rx_pending <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        cs_file[i] <= '0;
      end
    end else begin
      state      <= state_n;
      op         <= op_n;
      size_a     <= size_a_n;
      size_b     <= size_b_n;
      size_c     <= size_c_n;
      cs_addr    <= cs_addr_n;
      addr       <= addr_n;
      idx        <= idx_n;
      key_sr     <= key_sr_n;
      erase_cnt  <= erase_cnt_n;
      locked     <= locked_n;
      key_ok     <= key_ok_n;
      rx_pending <= rx_pending_n;
      if (cs_we) begin
        cs_file[cs_addr] <= cs_wd;
      end
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign erase_active = (state == S_ERASE);

endmodule

// File: tb/tb_updi_target_responder.sv
// tb_updi_target_responder
//   Drives UPDI byte streams into updi_target_responder through a modelled
//   RX FIFO, collects TX bytes, and compares them with a behavioural model of
//   the device (memory array, CS registers, lock/key state).
module tb_updi_target_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rd_en;
  logic       rx_empty = 1'b1;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_full;
  logic       break_detect;
  logic       locked;
  logic       erase_active;
  logic       protocol_error;

  always #5 clk = ~clk;

  updi_target_responder #(
    .MEM_SIZE(256),
    .MEM_BASE(16'h8000),
    .STATUSA_RESET(8'h30),
    .KEY_CHIPERASE(64'h4E564D4572617365)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_rd_en(rx_rd_en),
    .rx_empty(rx_empty),
    .tx_data(tx_data),
    .tx_wr_en(tx_wr_en),
    .tx_full(tx_full),
    .break_detect(break_detect),
    .locked(locked),
    .erase_active(erase_active),
    .protocol_error(protocol_error)
  );

  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  logic [7:0] exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   perr_cnt = 0;
  int   erase_cycles = 0;
  logic rd_prev = 1'b0;
  logic empty_toggle = 1'b0;
  logic rnd_full = 1'b0;

  // reference model state
  logic [7:0] m_mem[256];
  logic [7:0] m_cs[16];
  logic       m_locked;
  logic       m_key;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RX FIFO: the popped head appears on rx_data the next cycle
  always @(posedge clk) begin
    if (rx_rd_en && rx_q.size() > 0) rx_data <= rx_q.pop_front();
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_rd_en) begin
        chk("rx_back_to_back", rd_prev, 1'b0);
        chk("rx_pop_when_empty", rx_empty, 1'b0);
      end
      if (tx_wr_en) begin
        chk("tx_when_full", tx_full, 1'b0);
        tx_got.push_back(tx_data);
      end
      if (protocol_error) perr_cnt++;
      if (erase_active) erase_cycles++;
    end
    rd_prev  = rx_rd_en;
    rx_empty = (rx_q.size() == 0) || (empty_toggle && $urandom_range(0, 1) == 1);
  end

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] m_rd_mem(input logic [15:0] a);
    if (m_locked || a < 16'h8000 || a > 16'h80FF) return 8'h00;
    return m_mem[a - 16'h8000];
  endfunction

  task automatic m_wr_mem(input logic [15:0] a, input logic [7:0] d);
    if (!m_locked && a >= 16'h8000 && a <= 16'h80FF) m_mem[a - 16'h8000] = d;
  endtask

  function automatic logic [7:0] m_rd_cs(input logic [3:0] a);
    if (a == 4'h0) return 8'h30;
    if (a == 4'h7) return m_key ? 8'h08 : 8'h00;
    if (a == 4'hB) return ((m_cs[8] == 8'h59) ? 8'h20 : 8'h00) | (m_locked ? 8'h01 : 8'h00);
    return m_cs[a];
  endfunction

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic lds(input logic [15:0] a, input bit sa, input bit sb);
    logic [15:0] eff;
    eff = sa ? a : {8'h00, a[7:0]};
    send(8'h55); send({5'b0, sa, 1'b0, sb}); send(a[7:0]);
    if (sa) send(a[15:8]);
    exp_q.push_back(m_rd_mem(eff));
    if (sb) exp_q.push_back(m_rd_mem(eff + 16'd1));
  endtask

  task automatic sts(input logic [15:0] a, input bit sa, input bit sb,
                     input logic [7:0] d0, input logic [7:0] d1);
    logic [15:0] eff;
    eff = sa ? a : {8'h00, a[7:0]};
    send(8'h55); send({5'b01000, sa, 1'b0, sb} | 8'h00); send(a[7:0]);
    if (sa) send(a[15:8]);
    exp_q.push_back(8'h40);
    send(d0); m_wr_mem(eff, d0);
    if (sb) begin send(d1); m_wr_mem(eff + 16'd1, d1); end
    exp_q.push_back(8'h40);
  endtask

  task automatic ldcs(input logic [3:0] a);
    send(8'h55); send({4'h8, a});
    exp_q.push_back(m_rd_cs(a));
  endtask

  // returns 1 when this write starts a chip erase
  task automatic stcs(input logic [3:0] a, input logic [7:0] d, output bit erase);
    send(8'h55); send({4'hC, a}); send(d);
    erase = 0;
    if (a != 4'h0 && a != 4'h7 && a != 4'hB) begin
      if (a == 4'h8 && d == 8'h00 && m_cs[8] == 8'h59 && m_key) erase = 1;
      m_cs[a] = d;
    end
    if (erase) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
      m_locked = 0;
      m_key = 0;
    end
  endtask

  task automatic finish_txn(input string tag);
    int cyc;
    cyc = 0;
    while ((rx_q.size() != 0 || tx_got.size() < exp_q.size()) && cyc < 4000) begin
      @(posedge clk); #1;
      if (rnd_full) tx_full = ($urandom_range(0, 2) == 0);
      cyc++;
    end
    tx_full = 1'b0;
    chk({tag, "_timeout"}, 64'(cyc >= 4000), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(tx_got.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && tx_got.size() > 0) chk(tag, tx_got.pop_front(), exp_q.pop_front());
    exp_q.delete();
    tx_got.delete();
  endtask

  task automatic wait_rx_drained();
    int cyc;
    cyc = 0;
    while (rx_q.size() != 0 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    chk("rx_drain_timeout", 64'(cyc >= 2000), 64'd0);
  endtask

  logic [63:0] key_val;
  logic [63:0] id_val;
  bit          er;
  int          base;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    key_val = 64'h4E564D4572617365;
    id_val  = 64'h5550444946504741;
    rst = 1'b1; tx_full = 1'b0; break_detect = 1'b0;
    m_locked = 1'b1; m_key = 1'b0;
    for (int i = 0; i < 16; i++) m_cs[i] = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_locked", locked, 1'b1);
    chk("rst_erase_active", erase_active, 1'b0);
    chk("rst_tx_wr_en", tx_wr_en, 1'b0);
    chk("rst_rx_rd_en", rx_rd_en, 1'b0);
    chk("rst_protocol_error", protocol_error, 1'b0);

    ldcs(4'h0); finish_txn("ldcs_statusa");
    ldcs(4'hB); finish_txn("ldcs_sys_status");
    chk("locked_after_reset", locked, 1'b1);

    // locked device: reads 0, writes dropped
    lds(16'h8000, 1, 0); finish_txn("lds_locked");
    sts(16'h8010, 1, 0, 8'hAB, 8'h00); finish_txn("sts_locked");
    lds(16'h8010, 1, 0); finish_txn("lds_locked_reread");

    // SIB read
    send(8'h55); send(8'hE4);
    for (int i = 7; i >= 0; i--) exp_q.push_back(id_val[i*8 +: 8]);
    finish_txn("key_sib");

    // 16-byte key sets nothing
    send(8'h55); send(8'hE1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) send(key_val[i*8 +: 8]);
    finish_txn("key16");
    ldcs(4'h7); finish_txn("ldcs_key16");

    // unlock via chip erase
    send(8'h55); send(8'hE0);
    for (int i = 0; i < 8; i++) send(key_val[i*8 +: 8]);
    m_key = 1'b1;
    finish_txn("key8");
    ldcs(4'h7); finish_txn("ldcs_key_ok");
    stcs(4'h8, 8'h59, er); finish_txn("stcs_arm");
    ldcs(4'hB); finish_txn("ldcs_armed");
    erase_cycles = 0;
    stcs(4'h8, 8'h00, er); finish_txn("stcs_erase");
    chk("erase_started", er, 1'b1);
    begin
      int cyc;
      cyc = 0;
      while (erase_active && cyc < 1000) begin @(posedge clk); #1; cyc++; end
      chk("erase_timeout", 64'(cyc >= 1000), 64'd0);
    end
    chk("erase_len", 64'(erase_cycles), 64'd256);
    chk("locked_after_erase", locked, 1'b0);
    ldcs(4'h7); finish_txn("ldcs_key_cleared");
    lds(16'h8040, 1, 0); finish_txn("lds_erased");

    sts(16'h8010, 1, 0, 8'hAB, 8'h00); finish_txn("sts_unlocked");
    lds(16'h8010, 1, 0); finish_txn("lds_unlocked");
    lds(16'h7FFF, 1, 0); finish_txn("lds_below_base");
    sts(16'h8020, 1, 1, 8'h34, 8'h12); finish_txn("sts_word");
    lds(16'h8020, 1, 1); finish_txn("lds_word");
    sts(16'h80FF, 1, 1, 8'h5A, 8'hA5); finish_txn("sts_word_edge");
    lds(16'h80FF, 1, 1); finish_txn("lds_word_edge");

    // error paths
    base = perr_cnt;
    send(8'h00); finish_txn("bad_sync");
    chk("perr_bad_sync", 64'(perr_cnt - base), 64'd1);
    base = perr_cnt;
    send(8'h55); send(8'h20); ldcs(4'h0); finish_txn("after_ld_opcode");
    chk("perr_ld_opcode", 64'(perr_cnt - base), 64'd1);
    base = perr_cnt;
    send(8'h55); send(8'h08); ldcs(4'h0); finish_txn("after_bad_size");
    chk("perr_bad_size", 64'(perr_cnt - base), 64'd1);

    // break in the middle of an STS address
    send(8'h55); send(8'h44); send(8'h10);
    wait_rx_drained();
    repeat (4) @(posedge clk);
    #1 break_detect = 1'b1;
    @(posedge clk); #1 break_detect = 1'b0;
    ldcs(4'h0); finish_txn("after_break");

    // backpressure
    tx_full = 1'b1;
    ldcs(4'h0);
    wait_rx_drained();
    repeat (10) @(posedge clk);
    #1;
    chk("bp_held", 64'(tx_got.size()), 64'd0);
    tx_full = 1'b0;
    finish_txn("bp_release");

    // randomized traffic with RX gaps and TX backpressure
    empty_toggle = 1'b1;
    rnd_full = 1'b1;
    for (int t = 0; t < 60; t++) begin
      int          kind;
      logic [15:0] a;
      logic [3:0]  ca;
      logic [7:0]  d;
      kind = $urandom_range(0, 3);
      a    = 16'h7FF0 + 16'($urandom_range(0, 16'h120));
      ca   = 4'($urandom_range(0, 15));
      d    = ($urandom_range(0, 3) == 0) ? 8'h59 : 8'($urandom);
      case (kind)
        0: lds(a, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        1: sts(a, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        2: ldcs(ca);
        default: stcs(ca, d, er);
      endcase
      finish_txn("rnd");
    end
    empty_toggle = 1'b0;
    rnd_full = 1'b0;
    ldcs(4'hB); finish_txn("final_sys_status");
    chk("final_locked", locked, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updi_target_responder.md
Name: updi_target_responder

Overview:
- UPDI target-side responder: the device end of the UPDI link that the programmer drives.
- Consumes received bytes from a UART RX FIFO and parses SYNC, opcode, address, data and key fields.
- Services LDCS, STCS, LDS, STS and KEY against an internal CS register file and a small byte memory, returning data and ACKs through a UART TX FIFO.
- Serves as a synthesizable device model for loopback benches and FPGA self-test of the programmer.

Parameters:
- MEM_SIZE, 256, bytes of emulated memory.
- MEM_ADDR_BITS, $clog2(MEM_SIZE), memory index width.
- MEM_BASE, 16'h8000, UPDI address mapped to memory byte 0.
- STATUSA_RESET, 8'h30, reset/read-only value of CS reg 0x0.
- KEY_CHIPERASE, 64'h4E564D4572617365, chip-erase key; first received byte compared to bits [7:0].

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rx_data  in  8  RX FIFO head; valid the cycle after rx_rd_en
- rx_rd_en  out  1  pop RX FIFO
- rx_empty  in  1  RX FIFO empty
- tx_data  out  8  byte to TX FIFO
- tx_wr_en  out  1  push TX FIFO
- tx_full  in  1  TX FIFO full
- break_detect  in  1  one-cycle pulse from PHY on BREAK
- locked  out  1  ASI_SYS_STATUS.LOCKSTATUS
- erase_active  out  1  high during memory erase
- protocol_error  out  1  one-cycle pulse on bad SYNC or unsupported opcode

Behaviour:
- Reset: state WAIT_SYNC. All outputs 0 except locked=1. CS regs 0 except 0x0=STATUSA_RESET and 0xB=8'h01. Memory contents not reset.
- RX handshake:
  - rx_rd_en asserted only when !rx_empty and the state needs a byte; never on consecutive cycles.
  - rx_data sampled the following cycle.
- TX handshake:
  - tx_wr_en asserted only when !tx_full.
  - If tx_full is high, the byte is held and the FSM stalls.
- States:
  - WAIT_SYNC: byte 0x55 -> OPCODE. Any other byte -> pulse protocol_error, stay in WAIT_SYNC.
  - OPCODE, decoded on bits [7:5]:
    - 000 LDS: size_a=[3:2], size_b=[1:0].
    - 010 STS: size_a=[3:2], size_b=[1:0].
    - 100 LDCS: cs_addr=[3:0].
    - 110 STCS: cs_addr=[3:0].
    - 111 KEY: sib=[2], size_c=[1:0].
    - 001/011/101 and any reserved size encoding (size_a/size_b>1, size_c>1): pulse protocol_error -> WAIT_SYNC.
  - ADDR: receives 1 (size_a=0) or 2 (size_a=1) address bytes, little-endian; upper byte 0 when size_a=0.
    - LDS -> DATA_TX.
    - STS -> ACK_ADDR.
  - ACK_ADDR: send 0x40 -> DATA_RX.
  - DATA_RX: STS receives 1 or 2 bytes (size_b), written to addr, addr+1 -> ACK_DATA. STCS receives 1 byte -> write CS -> WAIT_SYNC.
  - ACK_DATA: send 0x40 -> WAIT_SYNC.
  - DATA_TX: LDS sends 1 or 2 bytes from addr, addr+1. LDCS sends 1 CS byte. Then -> WAIT_SYNC.
  - KEY_RX: receives 8 (size_c=0) or 16 (size_c=1) bytes, shifted in. No response.
    - sib=1: instead transmit 8 bytes "UPDIFPGA" ASCII, then -> WAIT_SYNC.
  - ERASE: counter 0..MEM_SIZE-1, one byte per cycle written 0xFF.
    - On completion: locked cleared, CS 0x7 bit3 cleared -> WAIT_SYNC.
    - RX bytes are not popped during ERASE.
- Memory access rules:
  - Address outside [MEM_BASE, MEM_BASE+MEM_SIZE-1]: read 0x00, write dropped, ACKs still sent.
  - While locked=1: all memory reads return 0x00, all writes dropped.
  - addr+1 is computed 16-bit with wrap; range check applies per byte.
- CS registers:
  - Read-only: 0x0, 0x7, 0xB. STCS to these is ignored.
  - Other registers are writable 8-bit.
  - KEY of 8 bytes matching KEY_CHIPERASE sets CS 0x7 bit3. A 16-byte or non-matching key sets nothing.
- Chip erase: STCS 0x8 = 0x59 then STCS 0x8 = 0x00 while CS 0x7 bit3=1 -> enter ERASE after the second STCS.
  - While CS 0x8 == 0x59, CS 0xB bit5=1.
- break_detect: from any state, including ERASE (erase abandoned, lock state unchanged), next state = WAIT_SYNC. Pending TX byte dropped; CS/memory retained.
- Simultaneous events: break_detect takes priority over any RX/TX action that cycle.
- No echo generation: single-wire echo is the PHY's concern.

Test Plan:
- Reset, then RX 55 80 -> TX 0x30. Then RX 55 8B -> TX 0x01. locked=1.
- Locked: RX 55 04 00 80 (LDS, word addr 0x8000) -> TX 0x00. RX 55 44 10 80 -> TX 40; then RX AB -> TX 40. Re-read still returns 0x00.
- Unlock: RX 55 E0 + key bytes 65 73 61 72 45 4D 56 4E; then STCS 55 C8 59 and 55 C8 00.
  - erase_active high for MEM_SIZE cycles, then locked=0; LDCS 0x7 -> 0x00.
  - Afterwards STS 0x8010=0xAB then LDS 0x8010 -> TX 0xAB. LDS 0x7FFF -> 0x00.
- Word STS/LDS (0x45/0x05) at 0x8020 with data 34 12 -> two ACKs; LDS returns 34 12.
- Error paths:
  - RX 0x00 in WAIT_SYNC -> protocol_error pulse.
  - RX 55 20 (LD) -> protocol_error pulse, then a following valid 55 80 is answered.
  - break_detect mid-STS address -> parser in WAIT_SYNC, no TX.
- Backpressure: tx_full held high 10 cycles during an LDCS reply -> no tx_wr_en until released, then exactly one 0x30 written. rx_empty toggling never causes back-to-back rx_rd_en.
